// File: rtl/tiled_matrix_multiplier.sv
// Signed N x N matrix multiplier C = A x B using LANES parallel MAC lanes, with an operand write port and a registered C read port.
// Optional macro SATURATE_EN: clamp C writes to the OW-bit signed range when the accumulator is wider than OW.
`timescale 1ns/1ps
module tiled_matrix_multiplier #(
   parameter int N     = 4,
   parameter int LANES = 2,
   parameter int DW    = 8,
   parameter int OW    = 32,
   parameter int IW    = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ld_en,
   input  logic          ld_sel,
   input  logic [IW-1:0] ld_i,
   input  logic [IW-1:0] ld_j,
   input  logic [DW-1:0] ld_data,
   input  logic [IW-1:0] z_i,
   input  logic [IW-1:0] z_j,
   output logic [OW-1:0] z_out,
   output logic          busy,
   output logic          done
);
   localparam int GROUPS = N / LANES;
   localparam int GW     = (GROUPS < 2) ? 1 : $clog2(GROUPS);
   localparam int AW     = 2 * DW + IW;

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t state, state_nxt;

   logic signed [DW-1:0]   a_mem [N][N];
   logic signed [DW-1:0]   b_mem [N][N];
   logic        [OW-1:0]   c_mem [N][N];

   logic [IW-1:0]          i_cnt, k_cnt;
   logic [GW-1:0]          g_cnt;
   logic signed [AW-1:0]   acc   [LANES];
   logic signed [2*DW-1:0] prod  [LANES];
   logic signed [AW-1:0]   fin   [LANES];
   logic [OW-1:0]          c_val [LANES];
   logic [IW-1:0]          col   [LANES];

   logic k_last, g_last, i_last;
   logic accept, ld_ok, rd_ok;

   assign k_last = (k_cnt == IW'(N - 1));
   assign g_last = (g_cnt == GW'(GROUPS - 1));
   assign i_last = (i_cnt == IW'(N - 1));
   assign accept = start && (state == IDLE || state == DONE);

   // Index range checks only matter when N does not fill the index space.
   generate
      if ((1 << IW) == N) begin : g_pow2
         assign ld_ok = 1'b1;
         assign rd_ok = 1'b1;
      end else begin : g_npow2
         assign ld_ok = (ld_i < IW'(N)) && (ld_j < IW'(N));
         assign rd_ok = (z_i < IW'(N)) && (z_j < IW'(N));
      end
   endgenerate

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = COMPUTE;
         COMPUTE: if (k_last && g_last && i_last) state_nxt = DONE;
         DONE:    if (start) state_nxt = COMPUTE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == COMPUTE);
      done = (state == DONE);
   end

   // ---------------- Operand store ----------------
   // NOTE: A/B are plain RAM with no reset; adding one would block RAM inference and is never needed.
   always_ff @(posedge clk) begin
      if (ld_en && ld_ok && state != COMPUTE) begin
         if (ld_sel) b_mem[ld_i][ld_j] <= ld_data;
         else        a_mem[ld_i][ld_j] <= ld_data;
      end
   end

   // ---------------- Schedule counters: k innermost, then g, then i ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_cnt <= '0;
         g_cnt <= '0;
         k_cnt <= '0;
      end else if (accept) begin
         i_cnt <= '0;
         g_cnt <= '0;
         k_cnt <= '0;
      end else if (state == COMPUTE) begin
         if (k_last) begin
            k_cnt <= '0;
            if (g_last) begin
               g_cnt <= '0;
               i_cnt <= i_cnt + 1'b1;
            end else begin
               g_cnt <= g_cnt + 1'b1;
            end
         end else begin
            k_cnt <= k_cnt + 1'b1;
         end
      end
   end

   // ---------------- MAC lanes ----------------
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         col[l]  = IW'(int'(g_cnt) * LANES + l);
         prod[l] = (2*DW)'(a_mem[i_cnt][k_cnt]) * (2*DW)'(b_mem[k_cnt][col[l]]);
         fin[l]  = acc[l] + AW'(prod[l]);
      end
   end

   generate
      if (AW <= OW) begin : g_extend
         always_comb begin
            for (int l = 0; l < LANES; l++) c_val[l] = OW'(fin[l]);
         end
      end else begin : g_narrow
`ifdef SATURATE_EN
         localparam logic signed [AW-1:0] SAT_HI = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
         localparam logic signed [AW-1:0] SAT_LO = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
         always_comb begin
            for (int l = 0; l < LANES; l++) begin
               if (fin[l] > SAT_HI)      c_val[l] = SAT_HI[OW-1:0];
               else if (fin[l] < SAT_LO) c_val[l] = SAT_LO[OW-1:0];
               else                      c_val[l] = fin[l][OW-1:0];
            end
         end
`else
         always_comb begin
            for (int l = 0; l < LANES; l++) c_val[l] = fin[l][OW-1:0];
         end
`endif
      end
   endgenerate

   // C must read as zero after reset, so unlike A/B it is a resettable register array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) acc[l] <= '0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) c_mem[r][c] <= '0;
      end else if (state == COMPUTE) begin
         for (int l = 0; l < LANES; l++) begin
            if (k_last) begin
               c_mem[i_cnt][col[l]] <= c_val[l];
               acc[l]               <= '0;
            end else begin
               acc[l] <= fin[l];
            end
         end
      end
   end

   // ---------------- Read port ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        z_out <= '0;
      else if (rd_ok) z_out <= c_mem[z_i][z_j];
      else            z_out <= '0;
   end

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// Self-checking bench: lane sweep (LANES 1/2/4) plus a DW=16/OW=16 overflow instance, read scoreboard and latency checks.
`timescale 1ns/1ps
module tb_tiled_matrix_multiplier;

   typedef struct {
      logic [1:0]  i;
      logic [1:0]  j;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          i;
      int          j;
      logic [31:0] exp;
      logic [15:0] exp_ov;
   } sb_t;

`ifdef SATURATE_EN
   localparam logic [15:0] OV_EXP = 16'h7FFF;
`else
   localparam logic [15:0] OV_EXP = 16'h0004;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ld_en = 1'b0;
   logic        ld_sel = 1'b0;
   logic [1:0]  ld_i = '0, ld_j = '0;
   logic [7:0]  ld_data = '0;
   logic [15:0] ov_data = 16'h7FFF;
   logic [1:0]  z_i = '0, z_j = '0;

   logic [31:0] z1, z2, z4;
   logic [15:0] zov;
   logic busy1, busy2, busy4, busyov;
   logic done1, done2, done4, doneov;

   int n_checks = 0;
   int n_fail   = 0;
   int ma [4][4];
   int mb [4][4];
   sb_t sb [$];
   vec_t id_tbl [16];

   always #5 clk = ~clk;

   tiled_matrix_multiplier #(.N(4), .LANES(1)) d1 (
      .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
      .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .z_i(z_i), .z_j(z_j),
      .z_out(z1), .busy(busy1), .done(done1));

   tiled_matrix_multiplier #(.N(4), .LANES(2)) d2 (
      .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
      .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .z_i(z_i), .z_j(z_j),
      .z_out(z2), .busy(busy2), .done(done2));

   tiled_matrix_multiplier #(.N(4), .LANES(4)) d4 (
      .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
      .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .z_i(z_i), .z_j(z_j),
      .z_out(z4), .busy(busy4), .done(done4));

   tiled_matrix_multiplier #(.N(4), .LANES(2), .DW(16), .OW(16)) dov (
      .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
      .ld_i(ld_i), .ld_j(ld_j), .ld_data(ov_data), .z_i(z_i), .z_j(z_j),
      .z_out(zov), .busy(busyov), .done(doneov));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic load(input bit sel, input int i, input int j, input int val);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_sel  = sel;
      ld_i    = 2'(i);
      ld_j    = 2'(j);
      ld_data = 8'(val);
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Present (i,j), push the expectation, and compare when the registered read appears.
   task automatic read_check(input int i, input int j, input logic [31:0] exp,
                             input logic [15:0] exp_ov, input string tag);
      sb_t e;
      @(negedge clk);
      z_i = 2'(i);
      z_j = 2'(j);
      e.i = i; e.j = j; e.exp = exp; e.exp_ov = exp_ov;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s C[%0d][%0d] lanes=1", tag, e.i, e.j), z1, e.exp);
      check($sformatf("%s C[%0d][%0d] lanes=2", tag, e.i, e.j), z2, e.exp);
      check($sformatf("%s C[%0d][%0d] lanes=4", tag, e.i, e.j), z4, e.exp);
      check($sformatf("%s C[%0d][%0d] ovf", tag, e.i, e.j), 32'(zov), 32'(e.exp_ov));
   endtask

   function automatic logic [31:0] model(input int i, input int j);
      int s = 0;
      for (int k = 0; k < 4; k++) s += ma[i][k] * mb[k][j];
      return 32'(s);
   endfunction

   task automatic check_all_model(input string tag);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) read_check(i, j, model(i, j), OV_EXP, tag);
   endtask

   // Start a run; optionally poke start and an A write mid-compute; check latencies and busy length.
   task automatic run(input bit poke, input string tag);
      int lat1 = -1, lat2 = -1, lat4 = -1, latov = -1, busy_n = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, " busy after start"}, 32'(busy2), 32'd1);
      check({tag, " done drops on start"}, 32'(done2), 32'd0);
      for (int t = 1; t <= 200; t++) begin
         if (busy2) busy_n++;
         if (poke && t == 5) begin
            start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = 8'd99;
         end
         if (poke && t == 6) begin
            start = 1'b0; ld_en = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done1 && lat1 < 0)  lat1  = t;
         if (done2 && lat2 < 0)  lat2  = t;
         if (done4 && lat4 < 0)  lat4  = t;
         if (doneov && latov < 0) latov = t;
         if (lat1 >= 0 && lat2 >= 0 && lat4 >= 0 && latov >= 0) break;
      end
      check({tag, " latency lanes=1"}, 32'(lat1), 32'd64);
      check({tag, " latency lanes=2"}, 32'(lat2), 32'd32);
      check({tag, " latency lanes=4"}, 32'(lat4), 32'd16);
      check({tag, " latency ovf"}, 32'(latov), 32'd32);
      check({tag, " busy cycles"}, 32'(busy_n), 32'd32);
      check({tag, " busy low in done"}, 32'(busy2), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) id_tbl[r*4+c] = '{2'(r), 2'(c), 32'(4*r + c)};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy2), 32'd0);
      check("reset done", 32'(done2), 32'd0);
      check("reset z_out", z2, 32'd0);
      check("reset z_out ovf", 32'(zov), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Identity: A = I, B[r][c] = 4r + c
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            load(1'b0, r, c, (r == c) ? 1 : 0);
            load(1'b1, r, c, 4*r + c);
         end
      run(1'b0, "identity");
      for (int v = 0; v < 16; v++)
         read_check(int'(id_tbl[v].i), int'(id_tbl[v].j), id_tbl[v].exp, OV_EXP, "identity");

      // Restart from DONE with start and an A write during COMPUTE: both must be ignored
      run(1'b1, "busy_protect");
      for (int v = 0; v < 16; v++)
         read_check(int'(id_tbl[v].i), int'(id_tbl[v].j), id_tbl[v].exp, OV_EXP, "busy_protect");

      // Signed operands: every C = -60
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            load(1'b0, r, c, -3);
            load(1'b1, r, c, 5);
            ma[r][c] = -3;
            mb[r][c] = 5;
         end
      run(1'b0, "signed");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) read_check(r, c, 32'hFFFF_FFC4, OV_EXP, "signed");

      // Reset at cycle 10 of COMPUTE
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst busy", 32'(busy2), 32'd0);
      check("midrst done", 32'(done2), 32'd0);
      check("midrst z_out", z2, 32'd0);
      check("midrst busy lanes=1", 32'(busy1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) read_check(r, c, 32'd0, 16'd0, "midrst_cleared");
      run(1'b0, "after_reset");
      check_all_model("after_reset");

      // Lane sweep on random operands
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            logic signed [7:0] va, vb;
            va = 8'($urandom_range(0, 255));
            vb = 8'($urandom_range(0, 255));
            ma[r][c] = int'(va);
            mb[r][c] = int'(vb);
            load(1'b0, r, c, ma[r][c]);
            load(1'b1, r, c, mb[r][c]);
         end
      run(1'b0, "random");
      check_all_model("random");

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
